// File: rtl/alu32_seq_unit_if.sv
// Request/response bus of the alu32_seq_unit execution unit.
// The master side is the ALU issue logic. The slave side is the unit itself.
// Optional flag outputs are present only when ALU_FLAGS_EN is defined.
interface alu32_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
`ifdef ALU_FLAGS_EN
    logic             zero;
    logic             carry;
`endif

    modport master (
        output in_valid, op, a, b, out_ready,
`ifdef ALU_FLAGS_EN
        input  zero, carry,
`endif
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
`ifdef ALU_FLAGS_EN
        output zero, carry,
`endif
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu32_seq_unit.sv
// alu32_seq_unit: handshaked 32-bit ALU with an iterative 1-bit/cycle shifter.
// The unit holds at most one request in flight. It steps IDLE -> (SHIFT) -> DONE -> IDLE.
// Optional macro ALU_FLAGS_EN adds registered zero/carry flag outputs.
module alu32_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    alu32_seq_unit_if.slave bus
);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               shl_q, shl_d;        // 1 = shift left, 0 = shift right
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               is_shift;
    logic               result_upd;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   shreg_step;

    assign accept     = bus.in_valid && (state_q == IDLE);
    assign is_shift   = bus.op[2] && bus.op[1];
    assign shamt      = bus.b[SHAMT_W-1:0];
    assign shreg_step = shl_q ? (shreg_q << 1) : (shreg_q >> 1);

    // Single-cycle ALU result. For a zero-distance shift the result is a.
    always_comb begin
        alu_res = bus.a;
        case (bus.op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res = bus.a;
        endcase
    end

    // State register plus all datapath flops. The reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            shl_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            shl_q       <= shl_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic. out_valid is registered so that it mirrors the DONE state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (is_shift && (shamt != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    // Datapath: load on accept, shift one bit per SHIFT cycle, and write result on completion.
    always_comb begin
        result_d   = result_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        shl_d      = shl_q;
        result_upd = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        shreg_d = bus.a;
                        cnt_d   = shamt;
                        shl_d   = (bus.op == OP_SLL);
                    end else begin
                        result_d   = alu_res;
                        result_upd = 1'b1;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shreg_step;
                cnt_d   = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d   = shreg_step;
                    result_upd = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output logic: the unit is ready only while idle.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = out_valid_q;
        bus.result    = result_q;
    end

`ifdef ALU_FLAGS_EN
    logic zero_q, zero_d;
    logic carry_q, carry_d;
    logic alu_carry;

    // Carry-out of ADD is detected as a wrapped sum. The SUB borrow is an unsigned a < b.
    always_comb begin
        alu_carry = 1'b0;
        if (bus.op == OP_ADD) begin
            alu_carry = ((bus.a + bus.b) < bus.a);
        end else if (bus.op == OP_SUB) begin
            alu_carry = (bus.a < bus.b);
        end
    end

    // Flags change only when result is written. A completed shift always clears carry.
    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (result_upd) begin
            zero_d  = (result_d == '0);
            carry_d = (state_q == IDLE) ? alu_carry : 1'b0;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Flag outputs.
    always_comb begin
        bus.zero  = zero_q;
        bus.carry = carry_q;
    end
`endif
endmodule
